// File: rtl/busca_instrucao.sv
// busca_instrucao: fetch stage, one outstanding memory request feeding a decoder FIFO; FETCH_CNT_EN adds n_busca/n_descarte counters
module busca_instrucao #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] end_prox,
    input  logic              end_valid,
    output logic              avanca,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_end,
    output logic              inst_valid,
    input  logic              inst_ready
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]       n_busca,
    output logic [15:0]       n_descarte
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic [1:0] {OCIOSO, ESPERA, DESCARTA} estado_t;
    estado_t estado, estado_prox;
    logic [DATA_W+ADDR_W-1:0] fila [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic captura, push, pop, drop;
    // capture only from idle, so a free slot always exists for the response
    assign captura = reset && !flush && end_valid && estado == OCIOSO && count < FULL;
    assign push = !flush && mem_ack && estado == ESPERA;
    assign pop = !flush && inst_valid && inst_ready;
    assign drop = mem_ack && (estado == DESCARTA || (estado == ESPERA && flush));
    assign avanca = captura;
    assign mem_req = estado != OCIOSO;
    assign inst_valid = count != '0;
    assign {inst, inst_end} = fila[rd_ptr];
    always_comb begin
        estado_prox = estado == OCIOSO ? (captura ? ESPERA : OCIOSO) : mem_ack ? OCIOSO : flush ? DESCARTA : estado;
    end
    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            estado <= OCIOSO;
            mem_addr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) fila[i] <= '0;
        end else begin
            estado <= estado_prox;
            if (captura) mem_addr <= end_prox;
            if (push) fila[wr_ptr] <= {mem_data, mem_addr};
            wr_ptr <= flush ? '0 : wr_ptr + PW'(push);
            rd_ptr <= flush ? '0 : rd_ptr + PW'(pop);
            count <= flush ? '0 : count + CW'(push) - CW'(pop);
        end
    end
`ifdef FETCH_CNT_EN
    always_ff @(posedge sys_clock) begin
        if (!reset) begin
            n_busca <= '0;
            n_descarte <= '0;
        end else begin
            n_busca <= n_busca + 16'(push);
            n_descarte <= n_descarte + (flush ? 16'(count) : 16'd0) + 16'(drop);
        end
    end
`endif
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: directed stimulus with an expected-instruction queue checked by a decoupled monitor
module tb_busca_instrucao;
    logic        sys_clock = 0;
    logic        reset, end_valid, avanca, flush, mem_req, mem_ack, inst_valid, inst_ready;
    logic [15:0] end_prox, mem_addr, mem_data, inst, inst_end;
`ifdef FETCH_CNT_EN
    logic [15:0] n_busca, n_descarte;
`endif
    int checks = 0, failures = 0;
    int exp_busca = 0, exp_desc = 0;
    logic [31:0] sb [$];
    logic [31:0] mon_e;

    busca_instrucao dut (
        .sys_clock(sys_clock), .reset(reset), .end_prox(end_prox), .end_valid(end_valid),
        .avanca(avanca), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .inst(inst), .inst_end(inst_end),
        .inst_valid(inst_valid), .inst_ready(inst_ready)
`ifdef FETCH_CNT_EN
        , .n_busca(n_busca), .n_descarte(n_descarte)
`endif
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clock);
        #1;
    endtask

    task automatic offer(input logic [15:0] a);
        int n = 0;
        end_prox = a;
        end_valid = 1;
        #1;
        while (!avanca && n < 50) begin
            step();
            #1;
            n++;
        end
        chk("avanca_capture", {31'd0, avanca}, 1);
        step();
        end_valid = 0;
        chk("mem_req_after_capture", {31'd0, mem_req}, 1);
        chk("mem_addr_after_capture", {16'd0, mem_addr}, {16'd0, a});
    endtask

    task automatic fetch(input logic [15:0] a, input logic [15:0] d);
        offer(a);
        mem_data = d;
        mem_ack = 1;
        sb.push_back({d, a});
        exp_busca++;
        step();
        mem_ack = 0;
    endtask

    task automatic drain();
        int n = 0;
        inst_ready = 1;
        while ((sb.size() != 0 || inst_valid) && n < 20) begin
            step();
            n++;
        end
        chk("drain_queue", sb.size(), 0);
        chk("drain_inst_valid", {31'd0, inst_valid}, 0);
    endtask

    task automatic chk_cnt(input string nm);
`ifdef FETCH_CNT_EN
        chk({nm, "_n_busca"}, {16'd0, n_busca}, exp_busca);
        chk({nm, "_n_descarte"}, {16'd0, n_descarte}, exp_desc);
`endif
    endtask

    always @(negedge sys_clock) begin
        if (reset && !flush && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop got=0x%0h exp=none", {inst, inst_end});
            end else begin
                mon_e = sb.pop_front();
                chk("head_inst", {16'd0, inst}, {16'd0, mon_e[31:16]});
                chk("head_end", {16'd0, inst_end}, {16'd0, mon_e[15:0]});
            end
        end
    end

    initial begin
        reset = 0; end_valid = 1; end_prox = 16'h1234; flush = 0;
        mem_ack = 0; mem_data = 0; inst_ready = 0;
        repeat (3) step();
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 0);
        chk("rst_inst", {16'd0, inst}, 0);
        chk("rst_inst_end", {16'd0, inst_end}, 0);
        chk("rst_avanca", {31'd0, avanca}, 0);
        chk_cnt("rst");
        end_valid = 0;
        reset = 1;
        step();
        inst_ready = 1;
        fetch(16'h0010, 16'hA5A5);
        chk("t1_inst_valid", {31'd0, inst_valid}, 1);
        chk("t1_inst", {16'd0, inst}, 16'hA5A5);
        chk("t1_inst_end", {16'd0, inst_end}, 16'h0010);
        drain();
        inst_ready = 0;
        fetch(16'h0020, 16'h1111);
        fetch(16'h0021, 16'h2222);
        end_prox = 16'h0022;
        end_valid = 1;
        repeat (3) begin
            #1;
            chk("full_no_avanca", {31'd0, avanca}, 0);
            step();
        end
        inst_ready = 1;
        fetch(16'h0022, 16'h3333);
        drain();
        inst_ready = 0;
        fetch(16'h0040, 16'h4444);
        offer(16'h0030);
        flush = 1;
        exp_desc += sb.size();
        sb.delete();
        step();
        flush = 0;
        end_prox = 16'h0100;
        end_valid = 1;
        #1;
        chk("fl_inst_valid", {31'd0, inst_valid}, 0);
        chk("fl_mem_req_held", {31'd0, mem_req}, 1);
        chk("fl_mem_addr_held", {16'd0, mem_addr}, 16'h0030);
        chk("fl_descarta_no_avanca", {31'd0, avanca}, 0);
        mem_data = 16'hDEAD;
        mem_ack = 1;
        exp_desc++;
        step();
        mem_ack = 0;
        chk("fl_drop_inst_valid", {31'd0, inst_valid}, 0);
        inst_ready = 1;
        fetch(16'h0100, 16'h0B0B);
        chk_cnt("fl");
        drain();
        offer(16'h0050);
        flush = 1;
        mem_ack = 1;
        mem_data = 16'hEEEE;
        exp_desc++;
        step();
        flush = 0;
        mem_ack = 0;
        chk("sc_mem_req", {31'd0, mem_req}, 0);
        chk("sc_inst_valid", {31'd0, inst_valid}, 0);
        end_prox = 16'h0051;
        end_valid = 1;
        #1;
        chk("sc_idle_avanca", {31'd0, avanca}, 1);
        end_valid = 0;
        chk_cnt("sc");
        step();
        inst_ready = 0;
        fetch(16'h0061, 16'h6161);
        offer(16'h0060);
        reset = 0;
        mem_ack = 1;
        mem_data = 16'hBAD0;
        sb.delete();
        exp_busca = 0;
        exp_desc = 0;
        step();
        chk("rr_mem_req", {31'd0, mem_req}, 0);
        chk("rr_inst_valid", {31'd0, inst_valid}, 0);
        chk("rr_mem_addr", {16'd0, mem_addr}, 0);
        reset = 1;
        step();
        mem_ack = 0;
        chk("rr_late_ack_inst_valid", {31'd0, inst_valid}, 0);
        chk("rr_late_ack_mem_req", {31'd0, mem_req}, 0);
        chk_cnt("rr");
        fetch(16'h0070, 16'h7070);
        offer(16'h0071);
        inst_ready = 1;
        mem_data = 16'h7171;
        mem_ack = 1;
        sb.push_back({16'h7171, 16'h0071});
        exp_busca++;
        step();
        mem_ack = 0;
        inst_ready = 0;
        chk("pp_inst_valid", {31'd0, inst_valid}, 1);
        chk("pp_inst_end", {16'd0, inst_end}, 16'h0071);
        chk("pp_inst", {16'd0, inst}, 16'h7171);
        drain();
        chk_cnt("end");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
